// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg : parametrised N-channel registered operand/source selector.
//
// This block replaces the fixed 8-bit 3:1 datapath select mux. Several
// producers (register file ports, immediate unit, ALU writeback) present words
// on per-channel valid/ready handshakes. One channel is granted per cycle and
// its word is captured into a single output register that feeds one consumer.
//
// A grant is chosen in one of two ways:
//   mode=0 : direct select by sel. Out-of-range codes clamp to the last channel.
//   mode=1 : round-robin. The scan starts at ptr and wraps modulo NCH. ptr moves
//            past each winner, but only when a round-robin transfer happens.
//
// Parameters
//   WIDTH : data width of each channel and of the output
//   NCH   : number of input channels (2..16)
//   SELW  : width of sel/out_ch/ptr; must equal ceil(log2(NCH)), min 1
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_mode       0 = direct select, 1 = round-robin
//   i_sel        channel index for direct mode
//   i_in_data    channel k at [k*WIDTH +: WIDTH]
//   i_in_valid   per-channel valid
//   o_in_ready   per-channel ready, at most one bit high
//   o_out_data   registered selected word
//   o_out_valid  output register holds a valid word
//   i_out_ready  consumer accepts the held word
//   o_out_ch     channel that produced o_out_data
//   o_stall_cnt  (only with MUX_RR_STALL_CNT_EN) saturating count of cycles
//                with out_valid && !out_ready
//
// Optional feature macro: MUX_RR_STALL_CNT_EN
// -----------------------------------------------------------------------------

// Per-channel round-robin lane: reports whether this channel requests, and
// how far it sits from the scan start. The scan order is ptr, ptr+1, ...
// modulo NCH, so the requesting lane with the smallest distance wins.
module mux_rr_reg_lane #(
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int CH   = 0
) (
  input  logic            i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_req,
  output logic [SELW-1:0] o_dist
);
  int w_d;

  always_comb begin
    w_d = CH - int'(i_ptr);
    if (w_d < 0) w_d = w_d + NCH;
  end

  assign o_req  = i_req;
  assign o_dist = SELW'(w_d);
endmodule

module mux_rr_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic [SELW-1:0]      i_sel,
  input  logic [NCH*WIDTH-1:0] i_in_data,
  input  logic [NCH-1:0]       i_in_valid,
  output logic [NCH-1:0]       o_in_ready,
  output logic [WIDTH-1:0]     o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [SELW-1:0]      o_out_ch
`ifdef MUX_RR_STALL_CNT_EN
  ,
  output logic [15:0]          o_stall_cnt
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
  } word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  word_t                       r_word;
  logic [SELW-1:0]             r_ptr;

  logic [NCH-1:0][WIDTH-1:0]   w_words;
  logic [NCH-1:0]              w_lane_req;
  logic [NCH-1:0][SELW-1:0]    w_lane_dist;

  logic [SELW-1:0]             w_eff_sel;
  logic                        w_dir_vld;
  logic [SELW-1:0]             w_rr_g;
  logic                        w_rr_vld;
  logic [SELW-1:0]             w_g;
  logic                        w_g_vld;
  logic                        w_ld;
  logic                        w_xfer;

  assign w_words = i_in_data;

  // ---------------------------------------------------------------------------
  // Round-robin lanes, one per channel
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mux_rr_reg_lane #(
      .NCH  (NCH),
      .SELW (SELW),
      .CH   (k)
    ) u_lane (
      .i_req  (i_in_valid[k]),
      .i_ptr  (r_ptr),
      .o_req  (w_lane_req[k]),
      .o_dist (w_lane_dist[k])
    );
  end

  // The requesting lane nearest to ptr (in scan order) wins. Distances are
  // unique across lanes, so the strict '<' never has to break a tie.
  always_comb begin
    int best;
    w_rr_g   = '0;
    w_rr_vld = 1'b0;
    best     = NCH;
    for (int k = 0; k < NCH; k++) begin
      if (w_lane_req[k] && (int'(w_lane_dist[k]) < best)) begin
        best     = int'(w_lane_dist[k]);
        w_rr_g   = SELW'(k);
        w_rr_vld = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Direct select. Codes at or beyond NCH map to the last channel, the way
  // the old 3:1 mux sent code 11 to its last input.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_eff_sel = i_sel;
    if (int'(i_sel) >= NCH) w_eff_sel = SELW'(NCH - 1);
  end

  assign w_dir_vld = i_in_valid[w_eff_sel];

  assign w_g     = i_mode ? w_rr_g   : w_eff_sel;
  assign w_g_vld = i_mode ? w_rr_vld : w_dir_vld;

  // ---------------------------------------------------------------------------
  // Handshake. The output register can load when it is empty or is being
  // drained this cycle, which gives one word per cycle with no bubble.
  // ---------------------------------------------------------------------------
  assign w_ld   = (r_state == ST_EMPTY) || i_out_ready;
  assign w_xfer = w_ld && w_g_vld && !i_rst;

  always_comb begin
    o_in_ready = '0;
    if (w_xfer) o_in_ready = NCH'(1) << w_g;
  end

  // ---------------------------------------------------------------------------
  // Output stage FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_ld)   w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Data and channel only move on a transfer. A drain without a refill
  // leaves them as they were; only valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
    end else if (w_xfer) begin
      r_word.data <= w_words[w_g];
      r_word.ch   <= w_g;
    end
  end

  // The pointer only advances on round-robin transfers. Direct-mode traffic
  // leaves the fairness position alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_xfer && i_mode) begin
      r_ptr <= (w_g == SELW'(NCH - 1)) ? '0 : w_g + SELW'(1);
    end
  end

  assign o_out_valid = (r_state == ST_FULL);
  assign o_out_data  = r_word.data;
  assign o_out_ch    = r_word.ch;

`ifdef MUX_RR_STALL_CNT_EN
  // Counts consecutive back-pressured cycles of the held word. It saturates
  // instead of wrapping, so a very long stall never reads as a short one.
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (o_out_valid && i_out_ready) begin
      r_stall_cnt <= '0;
    end else if (o_out_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
